// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// streams them one bit per clock onto X for the downstream serial-bit FSM.
module fsm_bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             abort,
  output logic             X,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  // GAP counts down to zero, so it is loaded with one less than its length.
  localparam logic [7:0] GAP_LOAD = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       gap_r, gap_s;
  logic             x_r, x_s;
  logic             done_r, done_s;
  logic             busy_r;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;

  // Handshake decode: ready only in IDLE or in a gapless last-bit cycle.
  always_comb begin
    last_s  = (state_r == ST_SHIFT) && (cnt_r == LAST_CNT);
    ready_s = 1'b0;
    if (abort) begin
      ready_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      ready_s = 1'b1;
    end else if (last_s && !HAS_GAP) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = data_valid && ready_s;
  end

  assign data_ready = ready_s;

  // Next-state and next-output logic; X defaults to the idle level.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    gap_s   = gap_r;
    x_s     = IDLE_LEVEL;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SHIFT;
          shift_s = data_in;
          cnt_s   = '0;
          x_s     = first_bit(data_in);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort || (last_s && HAS_GAP)) begin
          state_s = HAS_GAP ? ST_GAP : ST_IDLE;
          gap_s   = GAP_LOAD;
        end else if (last_s) begin
          if (accept_s) begin
            // Back-to-back: the next frame's first bit follows immediately.
            shift_s = data_in;
            cnt_s   = '0;
            x_s     = first_bit(data_in);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          shift_s = advance(shift_r);
          cnt_s   = cnt_r + 1'b1;
          x_s     = first_bit(advance(shift_r));
          done_s  = (cnt_s == LAST_CNT);
        end
      end
      ST_GAP: begin
        if (gap_r == 8'd0) begin
          state_s = ST_IDLE;
        end else begin
          gap_s = gap_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      gap_r   <= 8'd0;
      x_r     <= IDLE_LEVEL;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      gap_r   <= gap_s;
      x_r     <= x_s;
      done_r  <= done_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign X          = x_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

endmodule
